// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text timing generator.
package vga_text_pkg;

    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    localparam int CELL_W  = 8;
    localparam int CELL_H  = 16;
    localparam logic [7:0] CURSOR_GLYPH = 8'hDB;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic [2:0] col;
        logic [3:0] row;
    } vga_timing_t;

    // Idle-state timing bits: syncs deasserted, picture blanked.
    localparam vga_timing_t TIMING_RESET = '{hs: 1'b1, vs: 1'b1, blank: 1'b1, col: 3'd0, row: 4'd0};

    // row*80 + col built from two shifts so no multiplier is inferred.
    function automatic logic [11:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
        logic [11:0] r;
        r = {6'd0, row};
        return (r << 6) + (r << 4) + {5'd0, col};
    endfunction

endpackage

// File: rtl/vga_text_timing_if.sv
// Bundle between the timing generator (master) and the text RAM / pixel stage (slave).
// Cursor signals exist only when TEXT_CURSOR_EN is defined.
interface vga_text_timing_if;
    logic [11:0] text_addr;
    logic [7:0]  text_data;
    logic        hsync;
    logic        vsync;
    logic        VGA_blank;
    logic [2:0]  columna;
    logic [3:0]  fila;
    logic [7:0]  caracter;
    logic        frame_start;
`ifdef TEXT_CURSOR_EN
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
`endif

    modport master (
        output text_addr, hsync, vsync, VGA_blank, columna, fila, caracter, frame_start,
        input  text_data
`ifdef TEXT_CURSOR_EN
        , input cursor_col, cursor_row
`endif
    );

    modport slave (
        input  text_addr, hsync, vsync, VGA_blank, columna, fila, caracter, frame_start,
        output text_data
`ifdef TEXT_CURSOR_EN
        , output cursor_col, cursor_row
`endif
    );
endinterface

// File: rtl/vga_text_timing_sync_counter.sv
// Free-running pixel/line counters with raw (unregistered) sync, blank and frame-start.
module vga_sync_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       blank_raw,
    output logic       frame_start_raw
);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Advance the pixel counter; the end of the last line wraps both counters together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign hs_raw          = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw          = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign blank_raw       = (h_cnt >= H_VIS) || (v_cnt >= V_VIS);
    assign frame_start_raw = (h_cnt == 10'd0) && (v_cnt == 10'd0);
endmodule

// File: rtl/vga_text_timing.sv
// 640x480@60 text-mode timing front end: counters, text-RAM addressing and a
// two-stage alignment pipeline so every output lags the counters by 2 clk,
// matching the 1-clk read latency of the text RAM.
// Optional blinking block cursor is built when TEXT_CURSOR_EN is defined.
module vga_text_timing
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
`ifdef TEXT_CURSOR_EN
    , parameter int BLINK_FRAMES = 32
`endif
) (
    input  logic clk,
    input  logic rst_n,
    vga_text_timing_if.master bus
);
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        hs_raw;
    logic        vs_raw;
    logic        blank_raw;
    logic        frame_start_raw;
    vga_timing_t s1_timing;
    vga_timing_t s2_timing;
    logic [11:0] s1_addr;
    logic        s1_frame_start;
    logic        s2_frame_start;

    vga_sync_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_counter (
        .clk             (clk),
        .rst_n           (rst_n),
        .h_cnt           (h_cnt),
        .v_cnt           (v_cnt),
        .hs_raw          (hs_raw),
        .vs_raw          (vs_raw),
        .blank_raw       (blank_raw),
        .frame_start_raw (frame_start_raw)
    );

    // Stage 1: register timing bits and issue the text-RAM address (parked at 0 when blanked).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_timing      <= TIMING_RESET;
            s1_addr        <= '0;
            s1_frame_start <= 1'b0;
        end else begin
            s1_timing      <= '{hs: hs_raw, vs: vs_raw, blank: blank_raw,
                                col: h_cnt[2:0], row: v_cnt[3:0]};
            s1_addr        <= blank_raw ? 12'd0 : cell_addr(v_cnt[9:4], h_cnt[9:3]);
            s1_frame_start <= frame_start_raw;
        end
    end

    // Stage 2: delay timing one more clk so it lines up with the RAM read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_timing      <= TIMING_RESET;
            s2_frame_start <= 1'b0;
        end else begin
            s2_timing      <= s1_timing;
            s2_frame_start <= s1_frame_start;
        end
    end

    assign bus.text_addr   = s1_addr;
    assign bus.hsync       = s2_timing.hs;
    assign bus.vsync       = s2_timing.vs;
    assign bus.VGA_blank   = s2_timing.blank;
    assign bus.columna     = s2_timing.col;
    assign bus.fila        = s2_timing.row;
    assign bus.frame_start = s2_frame_start;

`ifdef TEXT_CURSOR_EN
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

    logic [15:0] frame_cnt;
    logic        blink;
    logic        hit_raw;
    logic        s1_hit;
    logic        s2_hit;

    // Count frame starts and flip the blink phase every BLINK_FRAMES frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            blink     <= 1'b0;
        end else if (frame_start_raw) begin
            if (frame_cnt == BLINK_LAST) begin
                frame_cnt <= '0;
                blink     <= ~blink;
            end else begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign hit_raw = !blank_raw && blink &&
                     (h_cnt[9:3] == bus.cursor_col) &&
                     (v_cnt[9:4] == {1'b0, bus.cursor_row}) &&
                     (v_cnt[3:0] >= 4'd14);

    // Carry the cursor hit through both stages so it stays aligned with the RAM data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_hit <= 1'b0;
            s2_hit <= 1'b0;
        end else begin
            s1_hit <= hit_raw;
            s2_hit <= s1_hit;
        end
    end

    assign bus.caracter = s2_hit ? CURSOR_GLYPH : bus.text_data;
`else
    assign bus.caracter = bus.text_data;
`endif
endmodule

// File: tb/tb_vga_text_timing.sv
// Directed bench for vga_text_timing with a shortened vertical frame
// (32 visible lines + 2/2/3 porch/sync/porch = 39 lines, 31200 clk per frame)
// so that full frames, the wrap and a mid-frame reset fit in a short run.
// Horizontal timing is the full 640/16/96/48 line.
// Position convention: after the m-th clk edge following reset release the
// outputs show counter position p = m-2, and text_addr shows p = m-1.
module tb_vga_text_timing;
    logic clk;
    logic rst_n;
    int   cyc;
    int   total_checks;
    int   passed_checks;

    int   prev_hs, prev_vs;
    int   hs_fall_at, vs_fall_at;
    int   first_hs_fall, first_vs_fall;
    int   hs_low_len, vs_low_len;
    int   last_fs, fs_period;

    vga_text_timing_if bus();

    vga_text_timing #(
        .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(3)
`ifdef TEXT_CURSOR_EN
        , .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous text RAM whose content at each address is addr[7:0].
    always @(posedge clk) bus.text_data <= bus.text_addr[7:0];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) passed_checks++;
        else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, actual, expected);
    endtask

    task automatic reset_monitors();
        cyc = 0;
        prev_hs = 1; prev_vs = 1;
        hs_fall_at = -1; vs_fall_at = -1;
        first_hs_fall = -1; first_vs_fall = -1;
        hs_low_len = -1; vs_low_len = -1;
        last_fs = -1; fs_period = -1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_hs == 1 && bus.hsync == 1'b0) begin
            hs_fall_at = cyc;
            if (first_hs_fall < 0) first_hs_fall = cyc;
        end
        if (prev_hs == 0 && bus.hsync == 1'b1 && hs_fall_at >= 0) hs_low_len = cyc - hs_fall_at;
        if (prev_vs == 1 && bus.vsync == 1'b0) begin
            vs_fall_at = cyc;
            if (first_vs_fall < 0) first_vs_fall = cyc;
        end
        if (prev_vs == 0 && bus.vsync == 1'b1 && vs_fall_at >= 0) vs_low_len = cyc - vs_fall_at;
        if (bus.frame_start) begin
            if (last_fs >= 0) fs_period = cyc - last_fs;
            last_fs = cyc;
        end
        prev_hs = int'(bus.hsync);
        prev_vs = int'(bus.vsync);
    endtask

    task automatic applyStimulus(input int target);
        while (cyc < target) step();
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_hsync"}, 32'(bus.hsync), 32'd1);
        checkOutput({tag, "_vsync"}, 32'(bus.vsync), 32'd1);
        checkOutput({tag, "_blank"}, 32'(bus.VGA_blank), 32'd1);
        checkOutput({tag, "_columna"}, 32'(bus.columna), 32'd0);
        checkOutput({tag, "_fila"}, 32'(bus.fila), 32'd0);
        checkOutput({tag, "_fs"}, 32'(bus.frame_start), 32'd0);
        checkOutput({tag, "_addr"}, 32'(bus.text_addr), 32'd0);
    endtask

    initial begin
        total_checks = 0;
        passed_checks = 0;
        rst_n = 1'b0;
`ifdef TEXT_CURSOR_EN
        bus.cursor_col = 7'd10;
        bus.cursor_row = 5'd1;
`endif
        reset_monitors();
        for (int i = 0; i < 3; i++) step();
        check_reset_values("rst");

        rst_n = 1'b1;
        reset_monitors();
        step();
        checkOutput("rel_fs_early", 32'(bus.frame_start), 32'd0);
        applyStimulus(2);
        checkOutput("p0_fs", 32'(bus.frame_start), 32'd1);
        checkOutput("p0_blank", 32'(bus.VGA_blank), 32'd0);
        checkOutput("p0_columna", 32'(bus.columna), 32'd0);
        checkOutput("p0_fila", 32'(bus.fila), 32'd0);
        checkOutput("p0_char", 32'(bus.caracter), 32'h00);

        applyStimulus(19);
        checkOutput("p17_columna", 32'(bus.columna), 32'd1);
        checkOutput("p17_char", 32'(bus.caracter), 32'h02);
        checkOutput("p17_fs", 32'(bus.frame_start), 32'd0);

        applyStimulus(641);
        checkOutput("h639_char", 32'(bus.caracter), 32'h4F);
        checkOutput("h639_columna", 32'(bus.columna), 32'd7);
        checkOutput("h639_blank", 32'(bus.VGA_blank), 32'd0);
        checkOutput("h640_addr", 32'(bus.text_addr), 32'd0);
        applyStimulus(642);
        checkOutput("h640_blank", 32'(bus.VGA_blank), 32'd1);
        checkOutput("h640_char", 32'(bus.caracter), 32'h00);

        applyStimulus(13924);
        checkOutput("r1c40_addr", 32'(bus.text_addr), 32'd120);
        applyStimulus(13925);
        checkOutput("r1c40_char", 32'(bus.caracter), 32'h78);
        checkOutput("r1c40_columna", 32'(bus.columna), 32'd3);
        checkOutput("r1c40_fila", 32'(bus.fila), 32'd1);

        applyStimulus(24082);
        checkOutput("f0_cursor_cell", 32'(bus.caracter), 32'h5A);
        checkOutput("f0_cursor_fila", 32'(bus.fila), 32'd14);

        applyStimulus(25440);
        checkOutput("last_vis_addr", 32'(bus.text_addr), 32'd159);
        applyStimulus(25441);
        checkOutput("last_vis_char", 32'(bus.caracter), 32'h9F);
        checkOutput("last_vis_columna", 32'(bus.columna), 32'd7);
        checkOutput("last_vis_fila", 32'(bus.fila), 32'd15);
        checkOutput("last_vis_blank", 32'(bus.VGA_blank), 32'd0);

        applyStimulus(25602);
        checkOutput("vblank_blank", 32'(bus.VGA_blank), 32'd1);

        applyStimulus(31201);
        checkOutput("wrap_pre_fs", 32'(bus.frame_start), 32'd0);
        checkOutput("wrap_pre_blank", 32'(bus.VGA_blank), 32'd1);
        applyStimulus(31202);
        checkOutput("wrap_fs", 32'(bus.frame_start), 32'd1);
        checkOutput("wrap_blank", 32'(bus.VGA_blank), 32'd0);
        checkOutput("wrap_columna", 32'(bus.columna), 32'd0);
        checkOutput("wrap_fila", 32'(bus.fila), 32'd0);

        checkOutput("fs_period", 32'(fs_period), 32'd31200);
        checkOutput("hs_first_fall", 32'(first_hs_fall), 32'd658);
        checkOutput("hs_low_len", 32'(hs_low_len), 32'd96);
        checkOutput("vs_first_fall", 32'(first_vs_fall), 32'd27202);
        checkOutput("vs_low_len", 32'(vs_low_len), 32'd1600);

        applyStimulus(54482);
        checkOutput("f1_cursor_fila13", 32'(bus.caracter), 32'h5A);
        applyStimulus(55282);
`ifdef TEXT_CURSOR_EN
        checkOutput("f1_cursor_cell", 32'(bus.caracter), 32'hDB);
`else
        checkOutput("f1_cursor_cell", 32'(bus.caracter), 32'h5A);
`endif
        applyStimulus(55290);
        checkOutput("f1_next_cell", 32'(bus.caracter), 32'h5B);

        applyStimulus(58700);
        checkOutput("pre_rst_columna", 32'(bus.columna), 32'd2);
        checkOutput("pre_rst_fila", 32'(bus.fila), 32'd2);
        checkOutput("pre_rst_vsync", 32'(bus.vsync), 32'd0);
        rst_n = 1'b0;
        step();
        check_reset_values("mid_rst");
        step();
        step();
        rst_n = 1'b1;
        reset_monitors();
        step();
        checkOutput("post_rst_fs1", 32'(bus.frame_start), 32'd0);
        checkOutput("post_rst_addr", 32'(bus.text_addr), 32'd0);
        step();
        checkOutput("post_rst_fs2", 32'(bus.frame_start), 32'd1);
        checkOutput("post_rst_blank", 32'(bus.VGA_blank), 32'd0);
        checkOutput("post_rst_columna", 32'(bus.columna), 32'd0);
        applyStimulus(11);
        checkOutput("post_rst_p9_col", 32'(bus.columna), 32'd1);
        checkOutput("post_rst_p9_char", 32'(bus.caracter), 32'h01);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
